// File: rtl/wbs_kdtree_slave_pkg.sv
// Shared constants and types for the KD-tree Wishbone slave: address map,
// decoded window and FSM state encodings, fixed read-back patterns.
package kdtree_wbs_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h3000_0000;
  localparam logic [31:0] ADDR_MASK_DEF = 32'hFFFF_0000;

  // Stream window offsets from the slave base
  localparam logic [31:0] OFF_QUERY = 32'h0001_0000;
  localparam logic [31:0] OFF_LEAF  = 32'h0002_0000;
  localparam logic [31:0] OFF_BEST  = 32'h0003_0000;
  localparam logic [31:0] OFF_NODE  = 32'h0004_0000;

  // CSR offsets within the base window
  localparam logic [15:0] CSR_MODE  = 16'h0000;
  localparam logic [15:0] CSR_DEBUG = 16'h0004;
  localparam logic [15:0] CSR_DONE  = 16'h0008;
  localparam logic [15:0] CSR_START = 16'h000C;
  localparam logic [15:0] CSR_BUSY  = 16'h0010;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;
  localparam logic [31:0] BAD0      = 32'hBAD0_0000;

  localparam logic [7:0] TIMEOUT_CYCLES = 8'd255;

  typedef enum logic [2:0] {
    WIN_CSR,
    WIN_QUERY,
    WIN_LEAF,
    WIN_BEST,
    WIN_NODE,
    WIN_NONE
  } win_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_ACK
  } state_e;

endpackage

// File: rtl/wbs_kdtree_slave_if.sv
// Wishbone classic bus bundle between the caravel wbs_* pins and the slave.
interface wbs_kdtree_slave_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wbs_kdtree_slave_addr_decode.sv
// Combinational address decoder: bus address -> window plus CSR offset.
// CSR offsets outside the defined register set decode as WIN_NONE.
module wbs_addr_decode
  import kdtree_wbs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter logic [31:0] ADDR_MASK = ADDR_MASK_DEF
) (
  input  logic [31:0] adr_i,
  output win_e        win_o,
  output logic [15:0] csr_off_o
);

  logic [31:0] sel_addr;
  logic [31:0] off;

  always_comb begin
    sel_addr  = adr_i & ADDR_MASK;
    off       = adr_i & ~ADDR_MASK;
    csr_off_o = off[15:0];
    win_o     = WIN_NONE;
    if (sel_addr == BASE_ADDR) begin
      case (off[15:0])
        CSR_MODE, CSR_DEBUG, CSR_DONE, CSR_START, CSR_BUSY:
          if (off[31:16] == '0) win_o = WIN_CSR;
        default: win_o = WIN_NONE;
      endcase
    end else if (sel_addr == BASE_ADDR + OFF_QUERY) begin
      win_o = WIN_QUERY;
    end else if (sel_addr == BASE_ADDR + OFF_LEAF) begin
      win_o = WIN_LEAF;
    end else if (sel_addr == BASE_ADDR + OFF_BEST) begin
      win_o = WIN_BEST;
    end else if (sel_addr == BASE_ADDR + OFF_NODE) begin
      win_o = WIN_NODE;
    end
  end

endmodule

// File: rtl/wbs_kdtree_slave.sv
// Wishbone classic slave for the KD-tree accelerator: CSRs plus stream push/pop
// windows. Define WBS_TIMEOUT_EN to abort stalled stream transfers after 255 cycles.
module wbs_kdtree_slave
  import kdtree_wbs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 11,
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter logic [31:0] ADDR_MASK  = ADDR_MASK_DEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  wbs_kdtree_slave_if.slave       wbs,
  output logic                    mode_o,
  output logic                    debug_o,
  output logic                    fsm_start_o,
  input  logic                    fsm_done_i,
  input  logic                    fsm_busy_i,
  output logic                    node_valid_o,
  input  logic                    node_ready_i,
  output logic [2*DATA_WIDTH-1:0] node_data_o,
  output logic                    leaf_valid_o,
  input  logic                    leaf_ready_i,
  output logic [DATA_WIDTH-1:0]   leaf_data_o,
  output logic                    query_valid_o,
  input  logic                    query_ready_i,
  output logic [DATA_WIDTH-1:0]   query_data_o,
  input  logic                    best_valid_i,
  output logic                    best_ready_o,
  input  logic [DATA_WIDTH-1:0]   best_data_i
);

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic                    debug_q, debug_d;
  logic                    sticky_q, sticky_d;
  logic                    start_q, start_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    node_valid_q, node_valid_d;
  logic                    leaf_valid_q, leaf_valid_d;
  logic                    query_valid_q, query_valid_d;
  logic [2*DATA_WIDTH-1:0] node_data_q, node_data_d;
  logic [DATA_WIDTH-1:0]   leaf_data_q, leaf_data_d;
  logic [DATA_WIDTH-1:0]   query_data_q, query_data_d;
`ifdef WBS_TIMEOUT_EN
  logic [7:0]              cnt_q, cnt_d;
`endif

  win_e        win;
  logic [15:0] csr_off;
  logic [31:0] csr_rdata;
  logic        ack;
  logic        req;
  logic        push_hs;
  logic        unused_bits;

  wbs_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_MASK (ADDR_MASK)
  ) u_decode (
    .adr_i     (wbs.wbs_adr_i),
    .win_o     (win),
    .csr_off_o (csr_off)
  );

  assign ack     = (state_q == ST_ACK);
  assign req     = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack;
  assign push_hs = (node_valid_q && node_ready_i) ||
                   (leaf_valid_q && leaf_ready_i) ||
                   (query_valid_q && query_ready_i);
  assign unused_bits = ^{wbs.wbs_sel_i[3:1], wbs.wbs_dat_i[31:2*DATA_WIDTH]};

  always_comb begin
    csr_rdata = '0;
    case (csr_off)
      CSR_MODE:  csr_rdata = {31'd0, mode_q};
      CSR_DEBUG: csr_rdata = {30'd0, sticky_q, debug_q};
      CSR_DONE:  csr_rdata = {31'd0, fsm_done_i};
      CSR_BUSY:  csr_rdata = {31'd0, fsm_busy_i};
      default:   csr_rdata = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    debug_d       = debug_q;
    sticky_d      = sticky_q;
    start_d       = 1'b0;
    rdata_d       = rdata_q;
    node_valid_d  = node_valid_q;
    leaf_valid_d  = leaf_valid_q;
    query_valid_d = query_valid_q;
    node_data_d   = node_data_q;
    leaf_data_d   = leaf_data_q;
    query_data_d  = query_data_q;
    best_ready_o  = 1'b0;
`ifdef WBS_TIMEOUT_EN
    cnt_d         = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          rdata_d = '0;
          state_d = ST_ACK;
          case (win)
            WIN_CSR: begin
              if (!wbs.wbs_we_i) begin
                rdata_d = csr_rdata;
              end else begin
                case (csr_off)
                  CSR_MODE:
                    if (wbs.wbs_sel_i[0]) mode_d = wbs.wbs_dat_i[0];
                  CSR_DEBUG: begin
                    if (wbs.wbs_sel_i[0]) debug_d = wbs.wbs_dat_i[0];
`ifdef WBS_TIMEOUT_EN
                    if (wbs.wbs_sel_i[0] && wbs.wbs_dat_i[1]) sticky_d = 1'b0;
`endif
                  end
                  CSR_START:
                    if (wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0]) start_d = 1'b1;
                  default: ;
                endcase
              end
            end
            WIN_QUERY:
              if (wbs.wbs_we_i) begin
                query_valid_d = 1'b1;
                query_data_d  = wbs.wbs_dat_i[DATA_WIDTH-1:0];
                state_d       = ST_PUSH;
              end
            WIN_LEAF:
              if (wbs.wbs_we_i) begin
                leaf_valid_d = 1'b1;
                leaf_data_d  = wbs.wbs_dat_i[DATA_WIDTH-1:0];
                state_d      = ST_PUSH;
              end
            WIN_NODE:
              if (wbs.wbs_we_i) begin
                node_valid_d = 1'b1;
                node_data_d  = wbs.wbs_dat_i[2*DATA_WIDTH-1:0];
                state_d      = ST_PUSH;
              end
            WIN_BEST:
              if (!wbs.wbs_we_i) state_d = ST_POP;
            default:
              rdata_d = wbs.wbs_we_i ? '0 : DEAD_BEEF;
          endcase
        end
      end
      ST_PUSH: begin
        // The word is delivered even if the master abandons the cycle.
        if (push_hs) begin
          node_valid_d  = 1'b0;
          leaf_valid_d  = 1'b0;
          query_valid_d = 1'b0;
          rdata_d       = '0;
          state_d       = (wbs.wbs_cyc_i && wbs.wbs_stb_i) ? ST_ACK : ST_IDLE;
        end
`ifdef WBS_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CYCLES - 8'd1) begin
          node_valid_d  = 1'b0;
          leaf_valid_d  = 1'b0;
          query_valid_d = 1'b0;
          rdata_d       = BAD0;
          sticky_d      = 1'b1;
          state_d       = ST_ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_POP: begin
        if (!wbs.wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (best_valid_i) begin
          best_ready_o = 1'b1;
          rdata_d      = 32'(best_data_i);
          state_d      = ST_ACK;
        end
`ifdef WBS_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CYCLES - 8'd1) begin
          rdata_d  = BAD0;
          sticky_d = 1'b1;
          state_d  = ST_ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_IDLE;
      mode_q        <= 1'b0;
      debug_q       <= 1'b0;
      sticky_q      <= 1'b0;
      start_q       <= 1'b0;
      rdata_q       <= '0;
      node_valid_q  <= 1'b0;
      leaf_valid_q  <= 1'b0;
      query_valid_q <= 1'b0;
      node_data_q   <= '0;
      leaf_data_q   <= '0;
      query_data_q  <= '0;
`ifdef WBS_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      debug_q       <= debug_d;
      sticky_q      <= sticky_d;
      start_q       <= start_d;
      rdata_q       <= rdata_d;
      node_valid_q  <= node_valid_d;
      leaf_valid_q  <= leaf_valid_d;
      query_valid_q <= query_valid_d;
      node_data_q   <= node_data_d;
      leaf_data_q   <= leaf_data_d;
      query_data_q  <= query_data_d;
`ifdef WBS_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign wbs.wbs_ack_o = ack;
  assign wbs.wbs_dat_o = ack ? rdata_q : '0;
  assign mode_o        = mode_q;
  assign debug_o       = debug_q;
  assign fsm_start_o   = start_q;
  assign node_valid_o  = node_valid_q;
  assign node_data_o   = node_data_q;
  assign leaf_valid_o  = leaf_valid_q;
  assign leaf_data_o   = leaf_data_q;
  assign query_valid_o = query_valid_q;
  assign query_data_o  = query_data_q;

endmodule

// File: tb/tb_wbs_kdtree_slave.sv
// Scoreboard bench for wbs_kdtree_slave: directed bus transfers push expected
// responses; independent monitors compare acks and stream handshakes.
module tb_wbs_kdtree_slave;
  import kdtree_wbs_pkg::*;

  localparam int DW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode_o, debug_o, fsm_start_o, fsm_done_i, fsm_busy_i;
  logic          node_valid_o, node_ready_i;
  logic [2*DW-1:0] node_data_o;
  logic          leaf_valid_o, leaf_ready_i;
  logic [DW-1:0] leaf_data_o;
  logic          query_valid_o, query_ready_i;
  logic [DW-1:0] query_data_o;
  logic          best_valid_i, best_ready_o;
  logic [DW-1:0] best_data_i;

  wbs_kdtree_slave_if bus ();

  always #5 clk = ~clk;

  wbs_kdtree_slave #(
    .DATA_WIDTH (DW),
    .BASE_ADDR  (32'h3000_0000),
    .ADDR_MASK  (32'hFFFF_0000)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs           (bus),
    .mode_o        (mode_o),
    .debug_o       (debug_o),
    .fsm_start_o   (fsm_start_o),
    .fsm_done_i    (fsm_done_i),
    .fsm_busy_i    (fsm_busy_i),
    .node_valid_o  (node_valid_o),
    .node_ready_i  (node_ready_i),
    .node_data_o   (node_data_o),
    .leaf_valid_o  (leaf_valid_o),
    .leaf_ready_i  (leaf_ready_i),
    .leaf_data_o   (leaf_data_o),
    .query_valid_o (query_valid_o),
    .query_ready_i (query_ready_i),
    .query_data_o  (query_data_o),
    .best_valid_i  (best_valid_i),
    .best_ready_o  (best_ready_o),
    .best_data_i   (best_data_i)
  );

  typedef struct {
    logic        chk;
    logic [31:0] dat;
    string       name;
  } exp_t;

  exp_t          rd_q[$];
  logic [2*DW-1:0] node_q[$];
  logic [DW-1:0] leaf_q[$];
  logic [DW-1:0] query_q[$];

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int best_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Ack monitor: every ack consumes one scoreboard entry
  always @(negedge clk) begin : ack_mon
    exp_t e;
    if (!rst) begin
      if (bus.wbs_ack_o) begin
        check("ack_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          if (e.chk) check(e.name, bus.wbs_dat_o, e.dat);
        end
      end else begin
        check("dat_idle_zero", bus.wbs_dat_o, 32'd0);
      end
      if (fsm_start_o) begin
        start_cnt++;
        check("start_with_ack", 32'(bus.wbs_ack_o), 32'd1);
      end
      if (best_ready_o) best_cnt++;
    end
  end

  always @(negedge clk) begin : push_mon
    if (!rst) begin
      if (node_valid_o && node_ready_i) begin
        check("node_expected", 32'(node_q.size() != 0), 32'd1);
        if (node_q.size() != 0) check("node_data", 32'(node_data_o), 32'(node_q.pop_front()));
      end
      if (leaf_valid_o && leaf_ready_i) begin
        check("leaf_expected", 32'(leaf_q.size() != 0), 32'd1);
        if (leaf_q.size() != 0) check("leaf_data", 32'(leaf_data_o), 32'(leaf_q.pop_front()));
      end
      if (query_valid_o && query_ready_i) begin
        check("query_expected", 32'(query_q.size() != 0), 32'd1);
        if (query_q.size() != 0) check("query_data", 32'(query_data_o), 32'(query_q.pop_front()));
      end
    end
  end

  // Caller must be at posedge+#1; returns at posedge+#1. lat = cycles from request to ack.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic chk, input logic [31:0] exp,
                         input string name, input bit hold, output int lat);
    exp_t e;
    e.chk = chk; e.dat = exp; e.name = name;
    rd_q.push_back(e);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    lat = -1;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.wbs_ack_o && lat < 400);
    if (!bus.wbs_ack_o) begin
      check({name, "_ack_seen"}, 32'(bus.wbs_ack_o), 32'd1);
      void'(rd_q.pop_back());
    end
    @(posedge clk); #1;
    if (!hold) begin
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    bit stable;
    rst = 1'b1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    fsm_done_i = 1'b0; fsm_busy_i = 1'b0;
    node_ready_i = 1'b0; leaf_ready_i = 1'b0; query_ready_i = 1'b0;
    best_valid_i = 1'b0; best_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({mode_o, debug_o, fsm_start_o, node_valid_o, leaf_valid_o,
                                query_valid_o, best_ready_o, bus.wbs_ack_o}), 32'd0);
    check("reset_dat", bus.wbs_dat_o, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // MODE / DEBUG CSRs
    wb_xfer(1'b1, 32'h3000_0000, 32'd1, 4'hF, 1'b0, 32'd0, "mode_wr", 1'b0, lat);
    check("mode_wr_lat", lat, 1);
    wb_xfer(1'b0, 32'h3000_0000, 32'd0, 4'hF, 1'b1, 32'h1, "mode_rd", 1'b0, lat);
    check("mode_rd_lat", lat, 1);
    check("mode_o", 32'(mode_o), 32'd1);
    wb_xfer(1'b1, 32'h3000_0004, 32'd1, 4'h0, 1'b0, 32'd0, "debug_wr_nosel", 1'b0, lat);
    check("debug_nosel", 32'(debug_o), 32'd0);
    wb_xfer(1'b1, 32'h3000_0004, 32'd1, 4'h1, 1'b0, 32'd0, "debug_wr", 1'b0, lat);
    wb_xfer(1'b0, 32'h3000_0004, 32'd0, 4'hF, 1'b1, 32'h1, "debug_rd", 1'b0, lat);
    check("debug_o", 32'(debug_o), 32'd1);

    // NODE pushes, then a back-to-back pair with strobe held
    node_ready_i = 1'b1;
    node_q.push_back({11'd55, 11'd1});
    wb_xfer(1'b1, 32'h3004_0001, 32'h0001_B801, 4'hF, 1'b0, 32'd0, "node_wr", 1'b0, lat);
    check("node_wr_lat", lat, 2);
    node_q.push_back({11'd7, 11'd9});
    wb_xfer(1'b1, 32'h3004_0000, 32'h0000_3809, 4'hF, 1'b0, 32'd0, "node_b2b_a", 1'b1, lat);
    check("node_b2b_a_lat", lat, 2);
    node_q.push_back({11'd2047, 11'd0});
    wb_xfer(1'b1, 32'h3004_FFFC, 32'hFFFF_F800, 4'hF, 1'b0, 32'd0, "node_b2b_b", 1'b0, lat);
    check("node_b2b_b_lat", lat, 2);
    check("node_b2b_acks", 32'(rd_q.size()), 32'd0);
    node_ready_i = 1'b0;

    // QUERY push, upper data bits discarded
    query_ready_i = 1'b1;
    query_q.push_back(11'h5A5);
    wb_xfer(1'b1, 32'h3001_0010, 32'h1234_55A5, 4'hF, 1'b0, 32'd0, "query_wr", 1'b0, lat);
    check("query_wr_lat", lat, 2);
    query_ready_i = 1'b0;

    // LEAF push stalled 10 cycles
    leaf_q.push_back(11'h3C3);
    fork
      wb_xfer(1'b1, 32'h3002_0000, 32'h0000_03C3, 4'hF, 1'b0, 32'd0, "leaf_wr", 1'b0, lat);
      begin
        @(posedge clk);
        stable = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (!(leaf_valid_o && leaf_data_o == 11'h3C3 && !bus.wbs_ack_o)) stable = 1'b0;
        end
        check("leaf_stall_hold", 32'(stable), 32'd1);
        @(posedge clk); #1 leaf_ready_i = 1'b1;
      end
    join
    leaf_ready_i = 1'b0;
    check("leaf_wr_lat", lat, 12);

    // BEST pop, data arrives 5 cycles into POP
    fork
      wb_xfer(1'b0, 32'h3003_0000, 32'd0, 4'hF, 1'b1, 32'd123, "best_rd", 1'b0, lat);
      begin
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 best_valid_i = 1'b1; best_data_i = 11'd123;
        @(negedge clk);
        check("best_ready_on_valid", 32'(best_ready_o), 32'd1);
        @(posedge clk); #1 best_valid_i = 1'b0;
      end
    join
    check("best_rd_lat", lat, 7);
    check("best_pulse_count", best_cnt, 1);

    // BEST read abandoned before data: no pop, no ack
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h3003_0000;
    repeat (3) @(posedge clk);
    #1 bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    best_valid_i = 1'b1; best_data_i = 11'd77;
    repeat (3) @(posedge clk);
    #1 best_valid_i = 1'b0;
    check("best_abort_no_pop", best_cnt, 1);

    // FSM_START pulse rules
    wb_xfer(1'b1, 32'h3000_000C, 32'd1, 4'hF, 1'b0, 32'd0, "start_wr", 1'b0, lat);
    check("start_pulse", start_cnt, 1);
    wb_xfer(1'b1, 32'h3000_000C, 32'd1, 4'h0, 1'b0, 32'd0, "start_nosel", 1'b0, lat);
    wb_xfer(1'b1, 32'h3000_000C, 32'd0, 4'hF, 1'b0, 32'd0, "start_zero", 1'b0, lat);
    check("start_no_extra", start_cnt, 1);
    wb_xfer(1'b0, 32'h3000_000C, 32'd0, 4'hF, 1'b1, 32'd0, "start_rd_zero", 1'b0, lat);

    // Live status CSRs
    fsm_busy_i = 1'b1;
    wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, 1'b1, 32'h1, "busy_rd", 1'b0, lat);
    fsm_busy_i = 1'b0;
    wb_xfer(1'b0, 32'h3000_0008, 32'd0, 4'hF, 1'b1, 32'h0, "done_rd0", 1'b0, lat);
    fsm_done_i = 1'b1;
    wb_xfer(1'b0, 32'h3000_0008, 32'd0, 4'hF, 1'b1, 32'h1, "done_rd1", 1'b0, lat);
    fsm_done_i = 1'b0;

    // Unmapped and write-only windows
    wb_xfer(1'b0, 32'h3000_0020, 32'd0, 4'hF, 1'b1, 32'hDEAD_BEEF, "unmapped_csr_rd", 1'b0, lat);
    check("unmapped_lat", lat, 1);
    wb_xfer(1'b0, 32'h5000_0000, 32'd0, 4'hF, 1'b1, 32'hDEAD_BEEF, "unmapped_rd", 1'b0, lat);
    wb_xfer(1'b1, 32'h3000_0020, 32'd0, 4'hF, 1'b0, 32'd0, "unmapped_wr", 1'b0, lat);
    wb_xfer(1'b0, 32'h3002_1234, 32'd0, 4'hF, 1'b1, 32'd0, "leaf_window_rd", 1'b0, lat);
    wb_xfer(1'b0, 32'h3000_0000, 32'd0, 4'hF, 1'b1, 32'h1, "mode_rd_after", 1'b0, lat);

`ifdef WBS_TIMEOUT_EN
    wb_xfer(1'b1, 32'h3002_0000, 32'h0000_0011, 4'hF, 1'b1, 32'hBAD0_0000, "leaf_timeout", 1'b0, lat);
    check("timeout_lat", lat, 256);
    check("timeout_valid_dropped", 32'(leaf_valid_o), 32'd0);
    wb_xfer(1'b0, 32'h3000_0004, 32'd0, 4'hF, 1'b1, 32'h3, "debug_sticky_rd", 1'b0, lat);
    wb_xfer(1'b1, 32'h3000_0004, 32'd2, 4'h1, 1'b0, 32'd0, "debug_clear", 1'b0, lat);
    wb_xfer(1'b0, 32'h3000_0004, 32'd0, 4'hF, 1'b1, 32'h0, "debug_cleared_rd", 1'b0, lat);
`endif

    // Reset asserted while a NODE push is stalled
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'h3004_0000; bus.wbs_dat_i = 32'h0000_0123; bus.wbs_sel_i = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("push_valid_before_rst", 32'(node_valid_o), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_drops_valid", 32'(node_valid_o), 32'd0);
    check("rst_no_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rst_clears_mode", 32'(mode_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(posedge clk); #1;
    wb_xfer(1'b0, 32'h3000_0000, 32'd0, 4'hF, 1'b1, 32'h0, "mode_rd_post_rst", 1'b0, lat);

    repeat (2) @(posedge clk);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("node_q_drained", 32'(node_q.size()), 32'd0);
    check("leaf_q_drained", 32'(leaf_q.size()), 32'd0);
    check("query_q_drained", 32'(query_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
